// File: rtl/lpc_pkg.sv
// Shared constants, register map and FSM encoding for the LPC synthesis decoder.
package lpc_pkg;
   localparam int ORDER     = 10;
   localparam int FRAME_LEN = 160;
   localparam int COEF_FRAC = 16;
   localparam int ACC_W     = 52;

   localparam logic [3:0] K_LAST = 4'(ORDER - 1);
   localparam logic [7:0] N_LAST = 8'(FRAME_LEN - 1);

   localparam logic [8:0] RES_BASE   = 9'd0;
   localparam logic [8:0] OUT_BASE   = 9'd160;
   localparam logic [8:0] COEF_BASE  = 9'd320;
   localparam logic [8:0] CTRL_START = 9'd340;
   localparam logic [8:0] CTRL_FIN   = 9'd341;

   localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-32768);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_STORE} state_t;

   function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] v);
      if (v > Y_MAX)      return 16'h7fff;
      else if (v < Y_MIN) return 16'h8000;
      else                return v[15:0];
   endfunction
endpackage

// File: rtl/lpc_decode.sv
// All-pole synthesis engine: one LOAD, ORDER MAC and one STORE cycle per sample,
// with filter history carried across frames.
module lpc_decode
   import lpc_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        clear,
   output logic [7:0]  res_addr,
   input  logic [15:0] res_data,
   output logic [3:0]  coef_idx,
   input  logic [31:0] coef_data,
   input  logic [7:0]  out_raddr,
   output logic [15:0] out_rdata,
   output logic        busy,
   output logic        done
);
   state_t                  state;
   logic [7:0]              n;
   logic [3:0]              k;
   logic signed [ACC_W-1:0] acc;
   logic signed [15:0]      hist [ORDER];
   logic [15:0]             out_mem [FRAME_LEN];
   logic signed [47:0]      prod;
   logic signed [ACC_W-1:0] acc_sh;
   logic [15:0]             y;

   assign res_addr  = n;
   assign coef_idx  = k;
   assign prod      = 48'($signed(coef_data)) * 48'(hist[k]);
   assign acc_sh    = acc >>> COEF_FRAC;
   assign y         = sat16(acc_sh);
   assign busy      = (state != S_IDLE);
   assign out_rdata = out_mem[out_raddr];

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
         done  <= 1'b0;
         n     <= '0;
         k     <= '0;
         acc   <= '0;
         for (int i = 0; i < ORDER; i++) hist[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               // clear lands in the same edge as start, so a combined write decodes from zero history
               if (clear) for (int i = 0; i < ORDER; i++) hist[i] <= '0;
               if (start) begin
                  done  <= 1'b0;
                  n     <= '0;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               acc   <= {{(ACC_W-16-COEF_FRAC){res_data[15]}}, res_data, {COEF_FRAC{1'b0}}};
               k     <= '0;
               state <= S_MAC;
            end
            S_MAC: begin
               acc <= acc + ACC_W'(prod);
               if (k == K_LAST) state <= S_STORE;
               else             k     <= k + 4'd1;
            end
            S_STORE: begin
               hist[0] <= y;
               for (int i = 1; i < ORDER; i++) hist[i] <= hist[i-1];
               if (n == N_LAST) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  n     <= n + 8'd1;
                  state <= S_LOAD;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (state == S_STORE) out_mem[n] <= y;
   end
endmodule

// File: rtl/lpc_decode_avalon.sv
// Avalon-MM wrapper: register map decode, residue/coefficient storage and the
// registered read port around the synthesis engine.
module lpc_decode_avalon
   import lpc_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   input  logic        write,
   input  logic        read,
   input  logic [8:0]  address,
   input  logic        chipselect
);
   logic [15:0] res_mem  [FRAME_LEN];
   logic [31:0] coef_mem [ORDER];
   logic        busy, done, start, clear, host_wr;
   logic        in_res, in_out, in_coef;
   logic [7:0]  res_addr, out_raddr;
   logic [3:0]  coef_idx;
   logic [4:0]  coef_off;
   logic [15:0] out_rdata, rd_val;

   assign in_res    = (address < OUT_BASE);
   assign in_out    = (address >= OUT_BASE) && (address < COEF_BASE);
   assign in_coef   = (address >= COEF_BASE) && (address < CTRL_START);
   assign out_raddr = 8'(address - OUT_BASE);
   assign coef_off  = 5'(address - COEF_BASE);

   // every host write, control included, is dropped while a frame is in flight
   assign host_wr = chipselect & write & ~busy;
   assign start   = host_wr && (address == CTRL_START) && writedata[0];
   assign clear   = host_wr && (address == CTRL_START) && writedata[1];

   always_ff @(posedge clock) begin
      if (host_wr) begin
         if (in_res) res_mem[address[7:0]] <= writedata;
         if (in_coef) begin
            if (coef_off[0]) coef_mem[coef_off[4:1]][31:16] <= writedata;
            else             coef_mem[coef_off[4:1]][15:0]  <= writedata;
         end
      end
   end

   always_comb begin
      rd_val = '0;
      if (in_res)                  rd_val = res_mem[address[7:0]];
      else if (in_out)             rd_val = out_rdata;
      else if (in_coef)            rd_val = coef_off[0] ? coef_mem[coef_off[4:1]][31:16]
                                                        : coef_mem[coef_off[4:1]][15:0];
      else if (address == CTRL_FIN) rd_val = {14'b0, busy, done};
   end

   always_ff @(posedge clock) begin
      if (reset)                    readdata <= '0;
      else if (chipselect && read)  readdata <= rd_val;
   end

   lpc_decode u_engine (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .clear     (clear),
      .res_addr  (res_addr),
      .res_data  (res_mem[res_addr]),
      .coef_idx  (coef_idx),
      .coef_data (coef_mem[coef_idx]),
      .out_raddr (out_raddr),
      .out_rdata (out_rdata),
      .busy      (busy),
      .done      (done)
   );
endmodule

// File: tb/tb_lpc_decode_avalon.sv
// Directed bench for lpc_decode_avalon: frame-level reference model plus literal pins.
module tb_lpc_decode_avalon;
   logic        clock = 1'b0;
   logic        reset, write, read, chipselect;
   logic [15:0] writedata, readdata;
   logic [8:0]  address;

   always #5 clock = ~clock;

   lpc_decode_avalon dut (
      .clock      (clock),
      .reset      (reset),
      .writedata  (writedata),
      .readdata   (readdata),
      .write      (write),
      .read       (read),
      .address    (address),
      .chipselect (chipselect)
   );

   int checks = 0, errors = 0, cyc = 0;

   typedef struct {
      logic [15:0] exp;
      int          due;
      int          addr;
   } chk_t;
   chk_t pend[$];

   int     m_res  [160];
   longint m_coef [10];
   int     m_hist [10];
   int     m_out  [160];

   always @(posedge clock) cyc <= cyc + 1;

   // single compare point for every read issued by the stimulus
   always @(negedge clock) begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
         chk_t c;
         c = pend.pop_front();
         checks++;
         if (readdata !== c.exp) begin
            errors++;
            $display("FAIL rd addr=%0d got=%h exp=%h (cycle %0d)", c.addr, readdata, c.exp, cyc);
         end
      end
   end

   function void chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endfunction

   task automatic wr(input int a, input int d);
      address = 9'(a); writedata = 16'(d); write = 1'b1; chipselect = 1'b1;
      @(posedge clock); #1;
      write = 1'b0; chipselect = 1'b0;
   endtask

   task automatic rd(input int a, input logic [15:0] e);
      address = 9'(a); read = 1'b1; chipselect = 1'b1;
      pend.push_back('{exp: e, due: cyc + 1, addr: a});
      @(posedge clock); #1;
      read = 1'b0; chipselect = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic set_res(input int i, input int v);
      wr(i, v);
      m_res[i] = v;
   endtask

   task automatic set_coef(input int k, input logic [31:0] v);
      wr(320 + 2*(k-1), int'(v[15:0]));
      wr(321 + 2*(k-1), int'(v[31:16]));
      m_coef[k-1] = longint'($signed(v));
   endtask

   // y[n] = floor(e[n] + sum a_k*y[n-k]), saturated to 16 bits
   function void model_frame();
      longint acc, q;
      for (int n = 0; n < 160; n++) begin
         acc = longint'(m_res[n]) * 65536;
         for (int k = 0; k < 10; k++) acc += m_coef[k] * longint'(m_hist[k]);
         q = acc >>> 16;
         if (q > 32767)  q = 32767;
         if (q < -32768) q = -32768;
         for (int k = 9; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = int'(q);
         m_out[n]  = int'(q);
      end
   endfunction

   // start in cycle T: busy seen at T+1 and T+1920, done at T+1921
   task automatic run_frame(input bit clr);
      wr(340, clr ? 3 : 1);
      if (clr) m_hist = '{default: 0};
      model_frame();
      rd(341, 16'h0002);
      idle(1918);
      rd(341, 16'h0002);
      rd(341, 16'h0001);
   endtask

   task automatic check_out();
      for (int n = 0; n < 160; n++) rd(160 + n, 16'(m_out[n]));
   endtask

   int decay_exp [11] = '{1000, 500, 250, 125, 62, 31, 15, 7, 3, 1, 0};

   initial begin
      reset = 1'b1; write = 1'b0; read = 1'b0; chipselect = 1'b0;
      writedata = '0; address = '0;
      m_hist = '{default: 0};
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      chk("readdata_after_reset", int'(readdata), 0);
      rd(341, 16'h0000);
      rd(400, 16'h0000);

      // pass-through
      for (int k = 1; k <= 10; k++) set_coef(k, 32'h0);
      for (int n = 0; n < 160; n++) set_res(n, n - 80);
      rd(5, 16'hffb5);
      rd(320, 16'h0000);
      run_frame(1'b1);
      check_out();
      chk("model_pass_y0", m_out[0], -80);
      chk("model_pass_y159", m_out[159], 79);
      rd(160, 16'hffb0);
      rd(319, 16'd79);

      // decay
      set_coef(1, 32'h0000_8000);
      for (int n = 0; n < 160; n++) set_res(n, n == 0 ? 1000 : 0);
      rd(320, 16'h8000);
      rd(321, 16'h0000);
      run_frame(1'b1);
      check_out();
      for (int i = 0; i < 11; i++) begin
         chk("model_decay", m_out[i], decay_exp[i]);
         rd(160 + i, 16'(decay_exp[i]));
      end

      // positive and negative saturation
      set_coef(1, 32'h0001_0000);
      for (int n = 0; n < 160; n++) set_res(n, 20000);
      run_frame(1'b1);
      check_out();
      rd(160, 16'd20000);
      rd(161, 16'h7fff);
      rd(319, 16'h7fff);
      for (int n = 0; n < 160; n++) set_res(n, -20000);
      run_frame(1'b1);
      check_out();
      rd(160, 16'hb1e0);
      rd(161, 16'h8000);
      chk("model_sat_neg", m_out[100], -32768);

      // history continuity, then clear
      for (int n = 0; n < 160; n++) set_res(n, n == 0 ? 5 : 0);
      run_frame(1'b1);
      check_out();
      rd(319, 16'd5);
      set_res(0, 0);
      run_frame(1'b0);
      check_out();
      rd(160, 16'd5);
      chk("model_hist_carry", m_out[0], 5);
      run_frame(1'b1);
      check_out();
      rd(160, 16'd0);

      // mid-frame start/clear/residue write are dropped
      set_coef(1, 32'h0000_8000);
      set_coef(2, 32'hffff_c000);
      set_coef(3, 32'h0000_2000);
      for (int n = 0; n < 160; n++) set_res(n, ((n * 37) % 200) - 100);
      wr(340, 3);
      m_hist = '{default: 0};
      model_frame();
      rd(341, 16'h0002);
      idle(498);
      wr(340, 3);
      wr(3, 16'h1234);
      rd(3, 16'(m_res[3]));
      idle(1417);
      rd(341, 16'h0002);
      rd(341, 16'h0001);
      check_out();

      // reset around sample 50, then a fresh frame from zero history
      wr(340, 1);
      idle(605);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      chk("readdata_after_midreset", int'(readdata), 0);
      rd(341, 16'h0000);
      m_hist = '{default: 0};
      run_frame(1'b0);
      check_out();

      idle(3);
      chk("pending_reads_drained", pend.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/lpc_decode_avalon.md
# lpc_decode_avalon

Avalon-MM slave that reconstructs one 160-sample speech frame from an LPC residue and 10 LPC coefficients by running the all-pole synthesis filter y[n] = e[n] + Σ a_k·y[n−k], k=1..10. It is the inverse of the LPC encoder peripheral: the host writes the residue and coefficients produced by the encoder, pulses start, polls the finish flag, then reads back samples. Filter history persists across frames, so consecutive frames decode continuously.

## Interface
Parameters:
- ORDER, 10, predictor order.
- FRAME_LEN, 160, samples per frame.
- COEF_FRAC, 16, fractional bits of each coefficient (signed Q15.16).

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- writedata  in  16  Avalon write data.
- readdata  out  16  Avalon read data, registered, read latency 1.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  9  16-bit word address.
- chipselect  in  1  qualifies read/write.

## Operation
Register map (word addresses):
- 0–159: residue e[0..159], signed 16b, R/W.
- 160–319: output y[0..159], signed 16b, read-only.
- 320–339: a_1..a_10, 32b each; even address = bits 15:0, odd = bits 31:16; R/W.
- 340 CTRL_START (W): bit0 = start, bit1 = clear history; both self-clearing.
- 341 CTRL_FIN (R): bit0 = done, bit1 = busy; other bits 0.
- Unmapped reads return 0x0000; unmapped writes ignored.

FSM: IDLE → LOAD → MAC → STORE → (LOAD or IDLE).
- IDLE: start accepted only here; clears done, n=0. Clear-history bit (accepted in IDLE only) zeroes h[1..10] in the same cycle; start+clear together clears first, then decodes from zero history.
- LOAD (1 cycle): acc ← sign-extend(e[n]) << COEF_FRAC, k=1.
- MAC (ORDER cycles): acc ← acc + a_k·h[k]; a_k 32b signed × h 16b signed = 48b; acc 52b signed, no overflow possible.
- STORE (1 cycle): y = acc >>> COEF_FRAC (arithmetic, floor), saturated to [−32768, 32767]; write y to out[n]; shift history (h[1] ← y); n++. After n=159 → IDLE, done ← 1.
- While busy: start, clear and all host writes dropped; reads are served (output region may be partially updated).
- Reset: FSM → IDLE, done=0, busy=0, history zeroed, readdata=0; residue/coefficient/output memories not reset (contents unspecified).

## Timing
- Start write in cycle T → busy=1 from T+1; 12 cycles per sample; done=1 and busy=0 from T+1921, held until next accepted start.
- Read of any address in cycle R → readdata valid in R+1; readdata holds last value when no read.
- Output sample n written at end of its STORE; readable one cycle later.
- Write and read in same cycle to same address: read returns old value.

## Structure
- Package lpc_pkg: ORDER, FRAME_LEN, COEF_FRAC, address constants (residue/output/coef bases, CTRL_START=340, CTRL_FIN=341), FSM state enum.
- Sub-module lpc_decode: synthesis engine (FSM, MAC, history, saturation, output RAM port); wrapper holds address decode, residue/coef storage, readdata register.

## Test plan
- Reset: after reset, read 341 → 0x0000; readdata 0 before any read.
- Pass-through: all a_k=0, e[n]=n−80 → y[n]=n−80 for all n; done observed exactly at T+1921, busy before.
- Decay: a_1=0x0000_8000 (0.5), rest 0, e[0]=1000, others 0 → y=1000,500,250,125,62,31,15,7,3,1,0… .
- Saturation: a_1=0x0001_0000, e[n]=20000 → y[0]=20000, y[n≥1]=32767; e[n]=−20000 → y[n≥1]=−32768.
- History: a_1=1.0, e[0]=5, rest 0 → all y=5; next frame e≡0 → all y=5; then start+clear → all y=0.
- Robustness: start and residue write issued mid-frame → ignored, done timing unchanged; reset at sample 50 → fin reads 0, new start completes 1921 cycles later with correct outputs.
